mod_div_unit: RTL and testbench
===============================

// Module: mod_div_unit
// PURPOSE
//  Parametrised sequential divide/modulo engine for the MIPS datapath (DIVU/REMU, MOD ops).
//  Radix-2 restoring shift-subtract: fixed WIDTH-cycle latency, independent of operand values.
//  Owns its datapath (dividend, divisor, partial remainder, iteration count).
//  Handshakes with the main control unit via start/busy/done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal values 2..64
// PORTS
//  CLK          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      request; sampled only in IDLE or DONE
//  dividend     in   WIDTH  numerator, latched on accepted start
//  divisor      in   WIDTH  denominator, latched on accepted start
//  op_signed    in   1      signed operation (present only with MOD_DIV_SIGNED_EN)
//  busy         out  1      1 while in RUN
//  done         out  1      one-cycle pulse; results valid in that cycle
//  quotient     out  WIDTH  registered; holds until the next completion
//  remainder    out  WIDTH  registered; holds until the next completion
//  div_by_zero  out  1      registered flag for the last completed op
// BEHAVIOUR
//  Reset: synchronous, active-high, on CLK. State IDLE.
//   Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//   Reset wins over every other input. Reset mid-RUN aborts the op; no done is generated.
//  State IDLE: start=1 latches the operands.
//   divisor!=0 -> RUN, count=0, partial remainder=0.
//   divisor==0 -> DONE directly.
//  State RUN, one iteration per edge:
//   - pr = {pr[WIDTH-2:0], dvd[WIDTH-1]}; dvd <<= 1.
//   - If pr >= dsr: pr -= dsr and the new quotient bit is 1; otherwise the bit is 0.
//   - The compare/subtract is WIDTH+1 bits wide so it never overflows.
//   - On the edge with count==WIDTH-1 -> DONE, and quotient/remainder are loaded.
//  State DONE: done=1 for exactly one cycle, then -> IDLE.
//   start=1 in DONE is accepted as in IDLE, giving back-to-back ops with no bubble.
//  Latency:
//   - start sampled at edge t, divisor!=0: done=1 in the cycle after edge t+WIDTH.
//   - divisor==0: done=1 in the cycle after edge t.
//  Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
//  Every other completion clears div_by_zero.
//  start while busy=1 is ignored. No queueing; input changes during RUN have no effect.
//  dividend < divisor: quotient=0, remainder=dividend, full WIDTH latency still taken.
//  busy and done are never both 1.
// CONFIGURATION
//  MOD_DIV_SIGNED_EN defined:
//   - op_signed port exists.
//   - When op_signed=1, operands are converted to magnitudes on the start edge.
//   - Quotient is negated when the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - Fix-up is applied on the edge that loads the results; latency unchanged.
//   - Overflow case MIN / -1: quotient=MIN, remainder=0, div_by_zero=0.
//   - Divide by zero: quotient=all ones, remainder=dividend (no sign fix-up).
//  MOD_DIV_SIGNED_EN undefined:
//   - op_signed port absent; all operations are unsigned.
// TESTING (WIDTH=8 unless noted)
//  100 / 7 -> done 8 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy=1 for 8 cycles.
//  0x37 / 0 -> done in the cycle after start; quotient=0xFF, remainder=0x37, div_by_zero=1; busy never 1.
//  3 / 10, then start held in the DONE cycle with 255 / 1 -> q=0,r=3; then q=255,r=0 exactly 8 cycles later.
//  Start 200/3, reset=1 on the 4th RUN cycle -> all outputs 0, busy=0; no done pulse for 10 cycles.
//  Start 50/5, new start 9/2 pulsed during RUN -> ignored; only q=10, r=0 reported.
//  MOD_DIV_SIGNED_EN, op_signed=1:
//   -7/2 -> q=0xFD, r=0xFF.
//   0x80/0xFF -> q=0x80, r=0.
//   Same -7/2 with op_signed=0 (0xF9/2) -> q=0x7C, r=1.

Source files
------------

// File: rtl/mod_div_unit.sv
// mod_div_unit: radix-2 restoring shift-subtract divide/modulo engine.
// Fixed WIDTH-cycle latency for a non-zero divisor; one cycle for divide by zero.
// Handshake: start (accepted in IDLE or DONE), busy (RUN), done (one-cycle pulse).
// Optional feature macro: MOD_DIV_SIGNED_EN adds the op_signed port and
// signed magnitude conversion with quotient/remainder sign fix-up.
module mod_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef MOD_DIV_SIGNED_EN
    input  logic             op_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Datapath registers: dvd shifts dividend bits out at the top and
    // quotient bits in at the bottom, so it ends up holding the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] pr;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dsr_is_zero;
    logic             sgn_op;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   pr_shift;
    logic [WIDTH:0]   pr_sub;
    logic             q_bit;
    logic [WIDTH-1:0] pr_nxt;
    logic [WIDTH-1:0] q_raw;

`ifdef MOD_DIV_SIGNED_EN
    assign sgn_op = op_signed;
`else
    assign sgn_op = 1'b0;
`endif

    assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
    assign dsr_is_zero = (divisor == '0);

    // Signed operands enter the array as magnitudes; MIN stays MIN, which
    // reads correctly as the unsigned magnitude 2**(WIDTH-1).
    assign dvd_mag = (sgn_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dsr_mag = (sgn_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step, computed WIDTH+1 bits wide so the compare and
    // subtract never overflow.
    assign pr_shift = {pr, dvd[WIDTH-1]};
    assign pr_sub   = pr_shift - {1'b0, dsr};
    assign q_bit    = (pr_shift >= {1'b0, dsr});
    assign pr_nxt   = q_bit ? pr_sub[WIDTH-1:0] : pr_shift[WIDTH-1:0];
    assign q_raw    = {dvd[WIDTH-2:0], q_bit};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE/DONE, iterate in RUN, pulse DONE once.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = dsr_is_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (count == LAST_ITER) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (accept) state_nxt = dsr_is_zero ? S_DONE : S_RUN;
                else        state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, load results on
    // the final iteration (or immediately for divide by zero).
    always_ff @(posedge CLK) begin
        if (reset) begin
            dvd         <= '0;
            dsr         <= '0;
            pr          <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd   <= dvd_mag;
            dsr   <= dsr_mag;
            pr    <= '0;
            count <= '0;
            neg_q <= sgn_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn_op && dividend[WIDTH-1];
            if (dsr_is_zero) begin
                // Raw dividend, no sign fix-up, for the divide-by-zero result.
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == S_RUN) begin
            dvd   <= q_raw;
            pr    <= pr_nxt;
            count <= count + 1'b1;
            if (count == LAST_ITER) begin
                quotient    <= neg_q ? -q_raw  : q_raw;
                remainder   <= neg_r ? -pr_nxt : pr_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_div_unit.sv
// tb_mod_div_unit: self-checking bench for mod_div_unit at WIDTH=8.
// Directed table, multi-cycle corner sequences, and random operations
// compared against an arithmetic reference model.
// Signed cases are exercised when MOD_DIV_SIGNED_EN is defined.
module tb_mod_div_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         op_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    mod_div_unit #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef MOD_DIV_SIGNED_EN
        .op_signed  (op_signed),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model straight from the arithmetic rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz);
        int sa, sb, qi, ri;
        if (b == 0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else if (s) begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            qi  = sa / sb;
            ri  = sa % sb;
            q   = qi[W-1:0];
            r   = ri[W-1:0];
            dbz = 1'b0;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
        end
    endfunction

    // Present an op for exactly one edge; returns one cycle after that edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        op_signed = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Wait (bounded) for done; reports cycles waited and busy cycles seen.
    task automatic wait_done(output int cyc, output int bcyc, output bit timed_out);
        cyc       = 0;
        bcyc      = 0;
        timed_out = 1'b0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) bcyc++;
            if (cyc > 3 * W) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                                 input logic edbz);
        int cyc, bcyc;
        bit to;
        int exp_lat;
        exp_lat = (b == 0) ? 0 : W;
        issue(a, b, s);
        wait_done(cyc, bcyc, to);
        check({name, " timeout"}, to, 0);
        check({name, " latency"}, cyc, exp_lat);
        check({name, " busy cycles"}, bcyc, exp_lat);
        check({name, " busy&done"}, busy & done, 0);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        check({name, " div_by_zero"}, div_by_zero, edbz);
        tick();
        check({name, " done one cycle"}, done, 0);
        check({name, " q hold"}, quotient, eq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcyc, dcnt;
        bit to;
        logic [W-1:0] a, b, eq, er;
        logic s, edbz;

        // Directed vectors {a, b, signed, q, r, dbz}
        vecs.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0});
        vecs.push_back('{8'h37,  8'h00,  1'b0, 8'hFF,  8'h37,  1'b1});
        vecs.push_back('{8'd3,   8'd10,  1'b0, 8'd0,   8'd3,   1'b0});
        vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0});
        vecs.push_back('{8'hF9,  8'd2,   1'b0, 8'h7C,  8'd1,   1'b0});
        vecs.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0});
        vecs.push_back('{8'd128, 8'd255, 1'b0, 8'd0,   8'd128, 1'b0});
        vecs.push_back('{8'd200, 8'd3,   1'b0, 8'd66,  8'd2,   1'b0});
        vecs.push_back('{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,   1'b1});
        vecs.push_back('{8'd254, 8'd127, 1'b0, 8'd2,   8'd0,   1'b0});
`ifdef MOD_DIV_SIGNED_EN
        vecs.push_back('{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0});
        vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0});
        vecs.push_back('{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0});
        vecs.push_back('{8'h80,  8'h00,  1'b1, 8'hFF,  8'h80,  1'b1});
`endif

        // Reset, with start asserted to show reset wins.
        reset     = 1'b1;
        start     = 1'b1;
        dividend  = 8'h12;
        divisor   = 8'h00;
        op_signed = 1'b0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("idle done", done, 0);

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                          vecs[i].q, vecs[i].r, vecs[i].dbz);
        end

        // Back-to-back: start held in the DONE cycle.
        issue(8'd3, 8'd10, 1'b0);
        wait_done(cyc, bcyc, to);
        check("b2b first timeout", to, 0);
        check("b2b first quotient", quotient, 0);
        check("b2b first remainder", remainder, 3);
        issue(8'd255, 8'd1, 1'b0);
        wait_done(cyc, bcyc, to);
        check("b2b second timeout", to, 0);
        check("b2b second latency", cyc, W);
        check("b2b second quotient", quotient, 255);
        check("b2b second remainder", remainder, 0);
        tick();

        // Reset on the 4th RUN cycle aborts the op.
        issue(8'd200, 8'd3, 1'b0);
        repeat (3) tick();
        check("abort busy before reset", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort div_by_zero", div_by_zero, 0);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        check("abort no done", dcnt, 0);

        // Start pulsed during RUN is ignored.
        issue(8'd50, 8'd5, 1'b0);
        repeat (2) tick();
        issue(8'd9, 8'd2, 1'b0);
        wait_done(cyc, bcyc, to);
        check("ignore timeout", to, 0);
        check("ignore latency", cyc, W - 3);
        check("ignore quotient", quotient, 10);
        check("ignore remainder", remainder, 0);
        tick();
        dcnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        check("ignore no second done", dcnt, 0);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
`ifdef MOD_DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            model(a, b, s, eq, er, edbz);
            run_and_check($sformatf("rnd%0d a=%0h b=%0h s=%0d", i, a, b, s), a, b, s, eq, er, edbz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
